// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 16x oversampling and a 3-sample majority vote at mid-bit.
// A stop bit sampled low reports a framing error, and the block then waits for the line to return high.
//
// state   | meaning
// s_idle  | line idle, waiting for rxs to fall
// s_start | validating the start bit (a glitch returns to idle)
// s_data  | shifting in 8 data bits, LSB first
// s_stop  | sampling the stop bit
// s_brk   | stop bit was low, waiting for the line to return high
module uart_rx_oversample #(
   parameter int clk_freq  = 1000000,
   parameter int baud_rate = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] doutrx,
   output logic       donerx,
   output logic       ferr,
   output logic       busy
);

   localparam int div_clks = clk_freq / (baud_rate * 16);
   localparam int dw       = (div_clks > 1) ? $clog2(div_clks) : 1;
   localparam logic [dw-1:0] div_load = dw'(div_clks - 1);

   typedef enum logic [2:0] {s_idle, s_start, s_data, s_stop, s_brk} state_t;

   state_t        state;
   logic          rx_meta, rxs;
   logic [dw-1:0] div_cnt;
   logic [3:0]    tick_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          smp7, smp8;
   logic          tick, vote, wrap, maj;

   assign tick = (div_cnt == '0);
   assign vote = tick && (tick_cnt == 4'd9);
   assign wrap = tick && (tick_cnt == 4'd15);
   // the third vote is the live sample taken at tick count 9
   assign maj  = (smp7 & smp8) | (smp7 & rxs) | (smp8 & rxs);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         state     <= s_idle;
         div_cnt   <= '0;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         smp7      <= 1'b0;
         smp8      <= 1'b0;
         doutrx    <= 8'h00;
         donerx    <= 1'b0;
         ferr      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
         donerx  <= 1'b0;
         ferr    <= 1'b0;

         if (state != s_idle) begin
            if (tick) begin
               div_cnt  <= div_load;
               tick_cnt <= tick_cnt + 4'd1;
            end else begin
               div_cnt <= div_cnt - 1'b1;
            end
            if (tick && tick_cnt == 4'd7) smp7 <= rxs;
            if (tick && tick_cnt == 4'd8) smp8 <= rxs;
         end

         case (state)
            s_idle: begin
               // divider restarts here so sampling is phased to the start edge
               if (!rxs) begin
                  state    <= s_start;
                  busy     <= 1'b1;
                  div_cnt  <= div_load;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
               end
            end
            s_start: begin
               if (vote && maj) begin
                  state <= s_idle;
                  busy  <= 1'b0;
               end else if (wrap) begin
                  state <= s_data;
               end
            end
            s_data: begin
               if (vote) shift_reg <= {maj, shift_reg[7:1]};
               if (wrap) begin
                  if (bit_cnt == 3'd7) state <= s_stop;
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            s_stop: begin
               // leave at mid stop bit so a back-to-back start edge is not missed
               if (vote) begin
                  if (maj) begin
                     doutrx <= shift_reg;
                     donerx <= 1'b1;
                     state  <= s_idle;
                     busy   <= 1'b0;
                  end else begin
                     ferr  <= 1'b1;
                     state <= s_brk;
                  end
               end
            end
            s_brk: begin
               if (rxs) begin
                  state <= s_idle;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= s_idle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, serial bit rate in bits/s.
REQ-003 clk  input  1  single clock for all logic, rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idle high; 8N1 framing; LSB first.
REQ-006 doutrx  output  8  last correctly received byte.
REQ-007 donerx  output  1  one-cycle pulse: doutrx updated with a new byte.
REQ-008 ferr  output  1  one-cycle pulse: stop bit sampled low (framing error).
REQ-009 busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 The block SHALL pass rx through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rxs).
REQ-011 The block SHALL generate a tick enable every DIV = clk_freq/(baud_rate*16) clocks, using truncating integer division (defaults: DIV=6, 96 clocks per bit).
REQ-012 The tick divider SHALL restart from 0 on the IDLE->START transition, so sampling aligns to the detected falling edge.
REQ-013 A 4-bit tick counter SHALL count 0..15 per bit and wrap to 0 at each bit boundary.
REQ-014 The bit value SHALL be the majority of rxs at tick counts 7, 8 and 9.
REQ-015 States: IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: rxs==0 -> START; otherwise remain in IDLE.
REQ-017 START: at tick count 9, a majority of 1 -> IDLE with no output (glitch reject); a majority of 0 -> DATA at the wrap.
REQ-018 DATA: 8 bits shift into the shift register LSB first, one per 16 ticks; after the 8th wrap -> STOP.
REQ-019 STOP: at tick count 9, a majority of 1 -> doutrx <= shift register, donerx=1 on the next clock, -> IDLE.
REQ-020 STOP: at tick count 9, a majority of 0 -> ferr=1 on the next clock, doutrx unchanged, -> BREAK.
REQ-021 BREAK: remain until rxs==1, then -> IDLE; no new start bit is accepted while in BREAK.
REQ-022 Return to IDLE from STOP happens at mid stop bit, so a next start edge 0.5 bit later is captured (back-to-back frames).
REQ-023 donerx and ferr SHALL never assert in the same cycle and SHALL each be exactly one clock wide.
REQ-024 Latency: donerx rises 1 clock after the tick-9 sample of the stop bit (~9.5 bit periods after the start edge, plus 2 synchronizer clocks).

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE; divider, tick counter, bit counter and shift register = 0; synchronizer flops = 1.
REQ-026 While rst=1 at a clock edge: doutrx=8'h00, donerx=0, ferr=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame, with no donerx or ferr for that frame.
REQ-028 After reset deasserts, reception SHALL resume on the next falling edge of rxs.

Verification (10 ns clock, defaults, bit = 960 ns)
REQ-029 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> doutrx=8'hA5, donerx exactly 1 cycle, ferr=0.
REQ-030 Frames 0x00 then 0xFF back-to-back with no idle gap -> two donerx pulses; doutrx=8'h00, then 8'hFF.
REQ-031 rx low for 30 ns then high -> no donerx or ferr; busy returns to 0 within 1 bit.
REQ-032 Frame 0x3C with stop bit 0, then rx held low 3 bits, then high -> one ferr pulse, doutrx keeps its prior value, busy=1 until rx high, then IDLE.
REQ-033 rst pulsed for 1 clock during bit 4 of frame 0x55 -> no donerx, doutrx=8'h00; the next frame 0x81 is received correctly.
REQ-034 A single-sample glitch (10 ns) at tick 8 of data bit 2 of frame 0xF0 -> majority vote masks it; doutrx=8'hF0.
